// File: rtl/misc_pkg.sv
// Shared types and constants for the two-word move CPU: FSM states,
// internal register codes, ALU opcodes and the flag-condition helper.
package misc_pkg;

    typedef enum logic [1:0] {
        FETCH_SRC = 2'd0,
        READ_SRC  = 2'd1,
        FETCH_DST = 2'd2,
        WRITE_DST = 2'd3
    } state_t;

    // Source codes 0..7 read PC-relative constants, 8 reads ACCU, 9..15 read flag tests
    localparam logic [3:0] REG_PC    = 4'd0;
    localparam logic [3:0] REG_PC2   = 4'd1;
    localparam logic [3:0] REG_PC4   = 4'd2;
    localparam logic [3:0] REG_PC6   = 4'd3;
    localparam logic [3:0] REG_PC8   = 4'd4;
    localparam logic [3:0] REG_PC10  = 4'd5;
    localparam logic [3:0] REG_PC12  = 4'd6;
    localparam logic [3:0] REG_PC14  = 4'd7;
    localparam logic [3:0] REG_ACCU  = 4'd8;
    localparam logic [3:0] REG_SF    = 4'd9;
    localparam logic [3:0] REG_ZF    = 4'd10;
    localparam logic [3:0] REG_CF    = 4'd12;

    // Destination codes 0..7 are (conditional) jumps
    localparam logic [3:0] REG_JMP   = 4'd0;
    localparam logic [3:0] REG_JS    = 4'd1;
    localparam logic [3:0] REG_JZ    = 4'd2;
    localparam logic [3:0] REG_JC    = 4'd4;

    localparam logic [2:0] ALU_LOAD  = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_SUBR  = 3'd2;
    localparam logic [2:0] ALU_ADD   = 3'd3;
    localparam logic [2:0] ALU_XOR   = 3'd4;
    localparam logic [2:0] ALU_OR    = 3'd5;
    localparam logic [2:0] ALU_AND   = 3'd6;
    localparam logic [2:0] ALU_SHR   = 3'd7;

    // True when every flag selected by sel (bit2 carry, bit1 zero, bit0 sign) is set
    function automatic logic flags_ok(input logic [2:0] sel, input logic carry,
                                      input logic zero, input logic sign);
        return (!sel[2] || carry) && (!sel[1] || zero) && (!sel[0] || sign);
    endfunction

endpackage

// File: rtl/misc_cpu_if.sv
// Memory bus between the move CPU (master) and its memory (slave).
interface misc_cpu_if #(parameter int L = 16);
    logic [L-1:0] addr;
    logic         req;
    logic         we;
    logic [L-1:0] wdata;
    logic [L-1:0] rdata;
    logic         ready;

    modport master (output addr, req, we, wdata, input rdata, ready);
    modport slave  (input addr, req, we, wdata, output rdata, ready);
endinterface

// File: rtl/misc_alu.sv
// Combinational ALU for writes to ACCU-side register codes 8..15.
module misc_alu
    import misc_pkg::*;
#(
    parameter int L = 16
) (
    input  logic [2:0]   op,
    input  logic [L-1:0] a,
    input  logic [L-1:0] b,
    input  logic         cin,
    output logic [L-1:0] out,
    output logic         cout,
    output logic         zout
);
    logic [L:0] wide;

    always_comb begin
        wide = '0;
        out  = b;
        cout = cin;
        case (op)
            ALU_LOAD: out = b;
            // Arithmetic runs one bit wider; bit L is carry or borrow
            ALU_SUB:  begin wide = {1'b0, a} - {1'b0, b}; out = wide[L-1:0]; cout = wide[L]; end
            ALU_SUBR: begin wide = {1'b0, b} - {1'b0, a}; out = wide[L-1:0]; cout = wide[L]; end
            ALU_ADD:  begin wide = {1'b0, a} + {1'b0, b}; out = wide[L-1:0]; cout = wide[L]; end
            ALU_XOR:  out = a ^ b;
            ALU_OR:   out = a | b;
            ALU_AND:  out = a & b;
            ALU_SHR:  begin out = {cin, b[L-1:1]}; cout = b[0]; end
            default:  out = b;
        endcase
        zout = (out == '0);
    end
endmodule

// File: rtl/misc_cpu.sv
// Move-only CPU: every instruction copies a source word to a destination word;
// low addresses (bits [L-1:4] zero) select internal registers, jumps and the ALU.
module misc_cpu
    import misc_pkg::*;
#(
    parameter int           L        = 16,
    parameter logic [L-1:0] RESET_PC = L'('h10)
) (
    input  logic       clock,
    input  logic       reset_n,
    misc_cpu_if.master bus
);
    state_t       state, nxt_state;
    logic [L-1:0] pc, inst, dtr, accu;
    logic [L-1:0] nxt_pc, nxt_inst, nxt_dtr, nxt_accu;
    logic         carry, zero, nxt_carry, nxt_zero;
    logic [L-1:0] src_val, alu_out, nxt_addr;
    logic         alu_cout, alu_zout, nxt_req, nxt_we, nxt_is_mem;

    logic [3:0] code;
    logic       is_reg, cond_ok, bus_done;

    assign code     = inst[3:0];
    assign is_reg   = (inst[L-1:4] == '0);
    assign cond_ok  = flags_ok(code[2:0], carry, zero, accu[L-1]);
    assign bus_done = bus.req && bus.ready;

    misc_alu #(.L(L)) u_alu (
        .op   (code[2:0]),
        .a    (accu),
        .b    (dtr),
        .cin  (carry),
        .out  (alu_out),
        .cout (alu_cout),
        .zout (alu_zout)
    );

    // pc already points past the source word here, so S = pc - 1
    always_comb begin
        if (!code[3])
            src_val = pc + L'({code[2:0], 1'b0}) - L'(1);
        else if (code[2:0] == 3'd0)
            src_val = accu;
        else
            src_val = L'(cond_ok);
    end

    always_comb begin
        nxt_state = state;
        nxt_pc    = pc;
        nxt_inst  = inst;
        nxt_dtr   = dtr;
        nxt_accu  = accu;
        nxt_carry = carry;
        nxt_zero  = zero;
        case (state)
            FETCH_SRC, FETCH_DST: begin
                if (bus_done) begin
                    nxt_inst  = bus.rdata;
                    nxt_pc    = pc + L'(1);
                    nxt_state = (state == FETCH_SRC) ? READ_SRC : WRITE_DST;
                end
            end
            READ_SRC: begin
                if (!is_reg) begin
                    if (bus_done) begin
                        nxt_dtr   = bus.rdata;
                        nxt_state = FETCH_DST;
                    end
                end else begin
                    nxt_dtr   = src_val;
                    nxt_state = FETCH_DST;
                end
            end
            WRITE_DST: begin
                if (!is_reg) begin
                    if (bus_done) nxt_state = FETCH_SRC;
                end else begin
                    nxt_state = FETCH_SRC;
                    if (!code[3]) begin
                        if (cond_ok) nxt_pc = dtr;
                    end else begin
                        nxt_accu  = alu_out;
                        nxt_carry = alu_cout;
                        nxt_zero  = alu_zout;
                    end
                end
            end
            default: nxt_state = FETCH_SRC;
        endcase

        // Bus outputs are registered from the next state so they stay stable through waits
        nxt_is_mem = (nxt_inst[L-1:4] != '0);
        nxt_addr   = nxt_inst;
        nxt_req    = 1'b1;
        nxt_we     = 1'b0;
        case (nxt_state)
            FETCH_SRC, FETCH_DST: nxt_addr = nxt_pc;
            READ_SRC:             nxt_req  = nxt_is_mem;
            WRITE_DST: begin
                nxt_req = nxt_is_mem;
                nxt_we  = nxt_is_mem;
            end
            default:              nxt_req  = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= FETCH_SRC;
            pc        <= RESET_PC;
            inst      <= '0;
            dtr       <= '0;
            accu      <= '0;
            carry     <= 1'b0;
            zero      <= 1'b1;
            bus.addr  <= RESET_PC;
            bus.req   <= 1'b0;
            bus.we    <= 1'b0;
            bus.wdata <= '0;
        end else begin
            state     <= nxt_state;
            pc        <= nxt_pc;
            inst      <= nxt_inst;
            dtr       <= nxt_dtr;
            accu      <= nxt_accu;
            carry     <= nxt_carry;
            zero      <= nxt_zero;
            bus.addr  <= nxt_addr;
            bus.req   <= nxt_req;
            bus.we    <= nxt_we;
            bus.wdata <= nxt_dtr;
        end
    end
endmodule

// File: tb/tb_misc_cpu.sv
// Directed bench for misc_cpu: word memory with programmable wait states and a write log.
module tb_misc_cpu;
    logic clock = 1'b0;
    logic reset_n = 1'b0;

    misc_cpu_if #(.L(16)) bus ();

    misc_cpu dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    logic [15:0] mem [0:65535];
    int          waits   = 0;
    bit          hold_wr = 1'b0;
    int          wcnt    = 0;
    int          wr_count = 0;
    int          stable_err = 0;
    logic [15:0] last_waddr = '0, last_wdata = '0;
    logic        pend_q = 1'b0, we_q = 1'b0;
    logic [15:0] addr_q = '0, wdata_q = '0;

    int errors = 0;
    int checks = 0;

    assign bus.rdata = mem[bus.addr];
    assign bus.ready = (wcnt >= waits) && !(hold_wr && bus.we);

    // Memory-side bookkeeping: write log, wait-state counter, stability monitor
    always @(posedge clock) begin
        if (bus.req && bus.ready && bus.we) begin
            wr_count   <= wr_count + 1;
            last_waddr <= bus.addr;
            last_wdata <= bus.wdata;
        end
        if (bus.req && !bus.ready) wcnt <= wcnt + 1;
        else                       wcnt <= 0;
        if (pend_q && bus.req && (bus.addr !== addr_q || bus.we !== we_q || bus.wdata !== wdata_q))
            stable_err <= stable_err + 1;
        pend_q  <= bus.req && !bus.ready;
        addr_q  <= bus.addr;
        we_q    <= bus.we;
        wdata_q <= bus.wdata;
    end

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic wait_fetch(input logic [15:0] target, output bit found);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (bus.req && !bus.we && bus.addr == target) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        mem[16'h10] = 16'h0100; mem[16'h11] = 16'h0300; mem[16'h100] = 16'h1234;
        @(negedge clock);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b want=0", bus.req); end
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL rst_we got=%b want=0", bus.we); end
        checks++; if (bus.addr !== 16'h0010) begin errors++; $display("FAIL rst_addr got=%h want=0010", bus.addr); end
        checks++; if (bus.wdata !== 16'h0000) begin errors++; $display("FAIL rst_wdata got=%h want=0000", bus.wdata); end
        checks++; if (dut.zero !== 1'b1 || dut.accu !== 16'h0 || dut.carry !== 1'b0) begin
            errors++; $display("FAIL rst_regs got accu=%h c=%b z=%b want accu=0000 c=0 z=1", dut.accu, dut.carry, dut.zero);
        end
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (bus.req !== 1'b1 || bus.addr !== 16'h0010) begin
            errors++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=0010", bus.req, bus.addr);
        end
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL first_we got=%b want=0", bus.we); end
    endtask

    task automatic test_load_add();
        bit found;
        mem[16'h10] = 16'h0100; mem[16'h11] = 16'h0008;
        mem[16'h12] = 16'h0101; mem[16'h13] = 16'h000B;
        mem[16'h100] = 16'h0005; mem[16'h101] = 16'hFFFE;
        do_reset();
        wait_fetch(16'h12, found);
        checks++; if (!found || dut.accu !== 16'h0005 || dut.zero !== 1'b0) begin
            errors++; $display("FAIL load found=%b accu=%h z=%b want 1 0005 0", found, dut.accu, dut.zero);
        end
        wait_fetch(16'h14, found);
        checks++; if (!found) begin errors++; $display("FAIL add_timeout got=0 want=1"); end
        checks++; if (dut.accu !== 16'h0003) begin errors++; $display("FAIL add_accu got=%h want=0003", dut.accu); end
        checks++; if (dut.carry !== 1'b1) begin errors++; $display("FAIL add_carry got=%b want=1", dut.carry); end
        checks++; if (dut.zero !== 1'b0) begin errors++; $display("FAIL add_zero got=%b want=0", dut.zero); end
    endtask

    task automatic test_cond_jump();
        logic [15:0] got;
        // Taken: straight out of reset ACCU=0, zero=1
        mem[16'h10] = 16'h0200; mem[16'h11] = 16'h0002; mem[16'h200] = 16'h0040;
        do_reset();
        got = 16'hDEAD;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.req && !bus.we && (bus.addr == 16'h40 || bus.addr == 16'h12)) begin got = bus.addr; break; end
        end
        checks++; if (got !== 16'h0040) begin errors++; $display("FAIL jz_taken got=%h want=0040", got); end
        // Not taken: load 7 first so zero clears
        mem[16'h10] = 16'h0201; mem[16'h11] = 16'h0008; mem[16'h201] = 16'h0007;
        mem[16'h12] = 16'h0200; mem[16'h13] = 16'h0002;
        do_reset();
        got = 16'hDEAD;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.req && !bus.we && (bus.addr == 16'h40 || bus.addr == 16'h14)) begin got = bus.addr; break; end
        end
        checks++; if (got !== 16'h0014) begin errors++; $display("FAIL jz_not_taken got=%h want=0014", got); end
        checks++; if (dut.zero !== 1'b0 || dut.accu !== 16'h0007) begin
            errors++; $display("FAIL jz_flags got z=%b accu=%h want z=0 accu=0007", dut.zero, dut.accu);
        end
    endtask

    task automatic test_wait_states();
        bit found;
        int n, w0, s0;
        mem[16'h10] = 16'h0100; mem[16'h11] = 16'h0300; mem[16'h100] = 16'hABCD;
        waits = 3;
        w0 = wr_count; s0 = stable_err;
        do_reset();
        wait_fetch(16'h10, found);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            n++;
            if (bus.req && !bus.we && bus.addr == 16'h12) break;
        end
        checks++; if (!found || n != 16) begin errors++; $display("FAIL wait_cycles got=%0d want=16", n); end
        checks++; if (wr_count - w0 != 1) begin errors++; $display("FAIL wait_writes got=%0d want=1", wr_count - w0); end
        checks++; if (last_waddr !== 16'h0300) begin errors++; $display("FAIL wait_waddr got=%h want=0300", last_waddr); end
        checks++; if (last_wdata !== 16'hABCD) begin errors++; $display("FAIL wait_wdata got=%h want=abcd", last_wdata); end
        checks++; if (stable_err != s0) begin errors++; $display("FAIL wait_stable got=%0d want=%0d", stable_err, s0); end
        waits = 0;
    endtask

    task automatic test_pc_source_alu();
        bit found;
        mem[16'h10] = 16'h0204; mem[16'h11] = 16'h0000; mem[16'h204] = 16'h0020;
        mem[16'h20] = 16'h0003; mem[16'h21] = 16'h0008;
        mem[16'h22] = 16'h0205; mem[16'h23] = 16'h000F; mem[16'h205] = 16'h0001;
        mem[16'h24] = 16'h0206; mem[16'h25] = 16'h0009; mem[16'h206] = 16'h0001;
        mem[16'h26] = 16'h000C; mem[16'h27] = 16'h0301;
        do_reset();
        wait_fetch(16'h20, found);
        checks++; if (!found) begin errors++; $display("FAIL jmp_target got=0 want=1"); end
        wait_fetch(16'h22, found);
        checks++; if (!found || dut.accu !== 16'h0026) begin errors++; $display("FAIL pc_src got=%h want=0026", dut.accu); end
        wait_fetch(16'h24, found);
        checks++; if (!found || dut.accu !== 16'h0000) begin errors++; $display("FAIL shr_accu got=%h want=0000", dut.accu); end
        checks++; if (dut.carry !== 1'b1 || dut.zero !== 1'b1) begin
            errors++; $display("FAIL shr_flags got c=%b z=%b want c=1 z=1", dut.carry, dut.zero);
        end
        wait_fetch(16'h26, found);
        checks++; if (!found || dut.accu !== 16'hFFFF) begin errors++; $display("FAIL sub_accu got=%h want=ffff", dut.accu); end
        checks++; if (dut.carry !== 1'b1 || dut.zero !== 1'b0) begin
            errors++; $display("FAIL sub_flags got c=%b z=%b want c=1 z=0", dut.carry, dut.zero);
        end
        wait_fetch(16'h28, found);
        checks++; if (!found || last_waddr !== 16'h0301 || last_wdata !== 16'h0001) begin
            errors++; $display("FAIL cf_src got addr=%h data=%h want 0301 0001", last_waddr, last_wdata);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        int w0;
        mem[16'h10] = 16'h0100; mem[16'h11] = 16'h0300; mem[16'h100] = 16'h5A5A;
        hold_wr = 1'b1;
        w0 = wr_count;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bus.we) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL midwait_we_seen got=0 want=1"); end
        @(negedge clock);
        checks++; if (bus.we !== 1'b1 || bus.addr !== 16'h0300) begin
            errors++; $display("FAIL midwait_hold got we=%b addr=%h want 1 0300", bus.we, bus.addr);
        end
        reset_n = 1'b0;
        @(negedge clock);
        checks++; if (bus.we !== 1'b0 || bus.req !== 1'b0) begin
            errors++; $display("FAIL midwait_drop got we=%b req=%b want 0 0", bus.we, bus.req);
        end
        repeat (2) @(negedge clock);
        hold_wr = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (bus.req !== 1'b1 || bus.addr !== 16'h0010 || bus.we !== 1'b0) begin
            errors++; $display("FAIL midwait_restart got req=%b addr=%h we=%b want 1 0010 0", bus.req, bus.addr, bus.we);
        end
        checks++; if (wr_count != w0) begin errors++; $display("FAIL midwait_nowrite got=%0d want=%0d", wr_count, w0); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        test_reset();
        test_load_add();
        test_cond_jump();
        test_wait_states();
        test_pc_source_alu();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
